// File: rtl/fifo_stream_reader_pkg.sv
// Shared package for the FIFO reader/writer engines.
//   - Default widths and depths used as parameter defaults by the engines.
//   - fifo_rd_port_t: bundle type for a synchronous FIFO read port
//     (r_en, empty, rdata).
//   - wrap_inc: modulo-N increment shared by buffer pointers and packet
//     indices.
package fifo_stream_reader_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BUF_DEPTH  = 3;
  localparam int DEF_PKT_LEN    = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef struct packed {
    logic                      r_en;
    logic                      empty;
    logic [DEF_DATA_WIDTH-1:0] rdata;
  } fifo_rd_port_t;

  // Next value of an index that counts 0 .. limit-1 and wraps.
  function automatic int wrap_inc(input int idx, input int limit);
    return (idx >= limit - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between a FIFO read port, the reader engine and the
// downstream stream consumer.
//   fifo_empty / fifo_r_en / fifo_rdata : FIFO read port
//   m_valid / m_ready / m_data / m_last : valid/ready output stream
// master = reader engine, slave = FIFO + stream consumer side.
interface fifo_stream_reader_if
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  fifo_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  fifo_empty,
    output fifo_r_en,
    input  fifo_rdata,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last
  );

  modport slave (
    output fifo_empty,
    input  fifo_r_en,
    output fifo_rdata,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last
  );
endinterface

// File: rtl/fifo_stream_reader_out_buf.sv
// Small circular output buffer with one push and one pop per cycle.
//   clk, rst_n  : clock, synchronous active-low reset
//   push        : write push_data at the tail (caller guarantees not full)
//   pop         : drop the head entry (caller guarantees not empty)
//   flush       : discard all entries; wins over push/pop
//   push_data   : data written on push
//   head_data   : oldest entry, meaningful only while occ != 0
//   occ         : number of stored entries, 0 .. BUF_DEPTH
module fifo_stream_reader_out_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int BUF_DEPTH  = DEF_BUF_DEPTH,
  localparam int PTR_W      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int OCC_W      = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wrap_inc(int'(wr_ptr), BUF_DEPTH));
      if (pop)  rd_ptr <= PTR_W'(wrap_inc(int'(rd_ptr), BUF_DEPTH));
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is data only; the pointers and occ define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Consumer-side engine for a synchronous FIFO with a 1-cycle registered
// read port. Reads are issued only when the result is guaranteed a buffer
// slot; the read latency is absorbed by the output buffer so the stream
// runs at one word per clock. Packet boundaries are tagged with m_last and
// transferred words are counted.
//   clk, rst_n  : clock, synchronous active-low reset
//   enable      : allow new FIFO reads (in-flight read still completes)
//   flush       : clear buffer, packet index and in-flight word
//   bus         : FIFO read port + output stream (master side)
//   busy        : read in flight or buffered data present
//   words_out   : running count of stream transfers, wraps
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int PKT_LEN    = DEF_PKT_LEN,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  fifo_stream_reader_if.master bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] words_out
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic             pending;
  logic             drop;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   committed;
  logic [IDX_W-1:0] pkt_idx;
  logic             push;
  logic             pop;

  // Slots already spoken for: buffered words plus the word in flight.
  // Issuing only below BUF_DEPTH makes buffer overflow impossible and keeps
  // m_ready out of the r_en path.
  assign committed     = {1'b0, occ} + (OCC_W + 1)'(pending);
  assign bus.fifo_r_en = enable & ~bus.fifo_empty & ~flush &
                         (committed < (OCC_W + 1)'(BUF_DEPTH));

  assign bus.m_valid = (occ != '0);
  assign bus.m_last  = bus.m_valid & (pkt_idx == IDX_W'(PKT_LEN - 1));
  assign busy        = pending | bus.m_valid;

  // Flush overrides both buffer operations so neither is counted.
  assign push = pending & ~drop & ~flush;
  assign pop  = bus.m_valid & bus.m_ready & ~flush;

  fifo_stream_reader_out_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (bus.fifo_rdata),
    .head_data (bus.m_data),
    .occ       (occ)
  );

  // Read-issue stage -> data-landing stage: pending marks that fifo_rdata
  // carries a fresh word at the next edge; drop poisons that word after a
  // flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      drop      <= 1'b0;
      pkt_idx   <= '0;
      words_out <= '0;
    end else begin
      pending <= bus.fifo_r_en;
      drop    <= flush & pending;
      if (flush) begin
        pkt_idx <= '0;
      end else if (pop) begin
        pkt_idx <= IDX_W'(wrap_inc(int'(pkt_idx), PKT_LEN));
      end
      if (pop) words_out <= words_out + 1'b1;
    end
  end

endmodule
